// File: rtl/wb_stage_regfile_pkg.sv
// Shared definitions for the writeback stage / register file slice.
//   DATA_W_DEF, REG_AW_DEF, CNT_W_DEF : default widths
//   REG_ZERO                          : hardwired-zero register index
//   resSel_e                          : result-select encoding (memtoregW)
package wb_stage_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SEL_ALU = 1'b0,
    SEL_MEM = 1'b1
  } resSel_e;

endpackage

// File: rtl/wb_stage_regfile_if.sv
// MEM/WB bundle plus ID-stage read ports.
//   master : pipeline side, drives the W slot and read addresses, sees read data / result
//   slave  : writeback stage, consumes the W slot, returns read data and resultW
interface wb_stage_regfile_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              validW;
  logic              regwriteW;
  logic              memtoregW;
  logic [DATA_W-1:0] aluoutW;
  logic [DATA_W-1:0] readdataW;
  logic [REG_AW-1:0] writeregW;
  logic [31:0]       instrW;
  logic [REG_AW-1:0] ra1D;
  logic [REG_AW-1:0] ra2D;
  logic [DATA_W-1:0] rd1D;
  logic [DATA_W-1:0] rd2D;
  logic [DATA_W-1:0] resultW;

  modport master (
    output validW, regwriteW, memtoregW, aluoutW, readdataW, writeregW, instrW, ra1D, ra2D,
    input  rd1D, rd2D, resultW
  );

  modport slave (
    input  validW, regwriteW, memtoregW, aluoutW, readdataW, writeregW, instrW, ra1D, ra2D,
    output rd1D, rd2D, resultW
  );
endinterface

// File: rtl/wb_stage_regfile_regfile.sv
// regfile_2r1w: architectural register file, NUM_RD read ports, one write port.
//   clk, rst_n : clock, async active-low reset (clears every entry)
//   we, wa, wd : write enable / address / data (writes to entry 0 are discarded)
//   ra, rd     : packed read address / data per port; address 0 reads 0, an address
//                matching an active write returns wd in the same cycle (write-through)
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NUM_RD = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [REG_AW-1:0]              wa,
  input  logic [DATA_W-1:0]              wd,
  input  logic [NUM_RD-1:0][REG_AW-1:0]  ra,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd
);
  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] rf [NREG];

  // Entry 0 is reset and never written, so it stays zero; the read mux still
  // forces zero so a bypass hit on address 0 can never leak through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (we && (wa != '0)) begin
      rf[wa] <= wd;
    end
  end

  genvar p;
  generate
    for (p = 0; p < NUM_RD; p++) begin : g_rd
      assign rd[p] = (ra[p] == '0)            ? '0 :
                     (we && (ra[p] == wa))    ? wd :
                                                rf[ra[p]];
    end
  endgenerate

endmodule

// File: rtl/wb_stage_regfile.sv
// wb_stage_regfile: writeback end of the MEM/WB pipeline.
//   clk, rst_n    : clock, async active-low reset
//   wb (slave)    : W-stage bundle in; rd1D/rd2D (bypassed reads) and resultW out
//   retire_cnt    : retired-instruction count (bubbles excluded), wraps
//   wr_cnt        : committed register-write count, wraps
// Optional feature macro RETIRE_TRACE_EN adds trace_valid/instr/wreg/wdata/we,
// a registered copy of each retiring slot, one cycle after W.
module wb_stage_regfile
  import wb_stage_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_stage_regfile_if.slave wb,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  wr_cnt
`ifdef RETIRE_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [31:0]       trace_instr,
  output logic [REG_AW-1:0] trace_wreg,
  output logic [DATA_W-1:0] trace_wdata,
  output logic              trace_we
`endif
);
  localparam logic [REG_AW-1:0] REG_ZERO_W = REG_AW'(REG_ZERO);

  resSel_e                  sel;
  logic                     we;
  logic [1:0][DATA_W-1:0]   rdPk;

  assign sel        = resSel_e'(wb.memtoregW);
  assign wb.resultW = (sel == SEL_MEM) ? wb.readdataW : wb.aluoutW;

  // Gating with rst_n keeps the bypass quiet while reset is held, so reads
  // return 0 and a commit coincident with reset assertion is dropped.
  assign we = rst_n & wb.validW & wb.regwriteW & (wb.writeregW != REG_ZERO_W);

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .NUM_RD (2)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (wb.writeregW),
    .wd    (wb.resultW),
    .ra    ({wb.ra2D, wb.ra1D}),
    .rd    (rdPk)
  );

  assign wb.rd1D = rdPk[0];
  assign wb.rd2D = rdPk[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      wr_cnt     <= '0;
    end else begin
      if (wb.validW) retire_cnt <= retire_cnt + 1'b1;
      if (we)        wr_cnt     <= wr_cnt + 1'b1;
    end
  end

`ifdef RETIRE_TRACE_EN
  localparam int STAGES = 1;

  logic [STAGES:0] vldPipe;

  assign vldPipe[0] = wb.validW & rst_n;

  // Payload loads only on a retiring slot so bubble garbage never reaches the trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldPipe[STAGES:1] <= '0;
      trace_instr       <= '0;
      trace_wreg        <= '0;
      trace_wdata       <= '0;
      trace_we          <= 1'b0;
    end else begin
      vldPipe[STAGES:1] <= vldPipe[STAGES-1:0];
      if (vldPipe[0]) begin
        trace_instr <= wb.instrW;
        trace_wreg  <= wb.writeregW;
        trace_wdata <= wb.resultW;
        trace_we    <= we;
      end
    end
  end

  assign trace_valid = vldPipe[STAGES];
`endif

endmodule

// File: tb/tb_wb_stage_regfile.sv
module tb_wb_stage_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_regfile_if #(.DATA_W(DW), .REG_AW(AW)) wb();

  logic [CW-1:0] retireCnt, wrCnt;
`ifdef RETIRE_TRACE_EN
  logic          traceValid, traceWe;
  logic [31:0]   traceInstr;
  logic [AW-1:0] traceWreg;
  logic [DW-1:0] traceWdata;
`endif

  wb_stage_regfile #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (wb.slave),
    .retire_cnt (retireCnt),
    .wr_cnt     (wrCnt)
`ifdef RETIRE_TRACE_EN
    ,
    .trace_valid (traceValid),
    .trace_instr (traceInstr),
    .trace_wreg  (traceWreg),
    .trace_wdata (traceWdata),
    .trace_we    (traceWe)
`endif
  );

  typedef struct {
    logic [DW-1:0] rd1, rd2, res;
    bit            chkRes;
    int            ret, wr;
    bit            tv, twe;
    logic [31:0]   ti;
    logic [AW-1:0] tw;
    logic [DW-1:0] td;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: architectural state as plain arrays/ints.
  logic [DW-1:0] mRf [32];
  int            mRet, mWr;
  exp_t          prevTr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] mRead(input logic [AW-1:0] a, input bit commit,
                                          input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (commit && a == wa) return wd;
    return mRf[a];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRf[i] = '0;
    mRet = 0;
    mWr = 0;
    prevTr = '{default: '0};
  endtask

  // One W slot: apply at negedge, queue the expected view, update model at posedge.
  task automatic drive(input bit rst, input bit v, input bit rw, input bit m2r,
                       input logic [DW-1:0] alu, input logic [DW-1:0] ld,
                       input logic [AW-1:0] wr, input logic [31:0] ins,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    exp_t e;
    bit commit;
    logic [DW-1:0] res;
    @(negedge clk);
    rst_n        = rst;
    wb.validW    = v;
    wb.regwriteW = rw;
    wb.memtoregW = m2r;
    wb.aluoutW   = alu;
    wb.readdataW = ld;
    wb.writeregW = wr;
    wb.instrW    = ins;
    wb.ra1D      = a1;
    wb.ra2D      = a2;
    if (!rst) modelReset();
    res    = m2r ? ld : alu;
    commit = rst && v && rw && (wr != 0);
    e = prevTr;
    e.rd1    = mRead(a1, commit, wr, res);
    e.rd2    = mRead(a2, commit, wr, res);
    e.res    = res;
    e.chkRes = v;
    e.ret    = mRet;
    e.wr     = mWr;
    q.push_back(e);
    @(posedge clk);
    if (rst) begin
      if (commit) begin
        mRf[wr] = res;
        mWr = (mWr + 1) % (1 << CW);
      end
      if (v) begin
        mRet = (mRet + 1) % (1 << CW);
        prevTr.tv = 1; prevTr.ti = ins; prevTr.tw = wr; prevTr.td = res; prevTr.twe = commit;
      end else begin
        prevTr.tv = 0;
      end
    end
  endtask

  task automatic bubble(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    drive(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
          AW'($urandom), $urandom, a1, a2);
  endtask

  // Monitor: combinational outputs are stable 2 time units after the driver's negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd1D", 64'(wb.rd1D), 64'(e.rd1));
        chk("rd2D", 64'(wb.rd2D), 64'(e.rd2));
        if (e.chkRes) chk("resultW", 64'(wb.resultW), 64'(e.res));
        chk("retire_cnt", 64'(retireCnt), 64'(e.ret));
        chk("wr_cnt", 64'(wrCnt), 64'(e.wr));
`ifdef RETIRE_TRACE_EN
        chk("trace_valid", 64'(traceValid), 64'(e.tv));
        if (e.tv) begin
          chk("trace_instr", 64'(traceInstr), 64'(e.ti));
          chk("trace_wreg", 64'(traceWreg), 64'(e.tw));
          chk("trace_wdata", 64'(traceWdata), 64'(e.td));
          chk("trace_we", 64'(traceWe), 64'(e.twe));
        end
`endif
      end
    end
  end

  initial begin
    modelReset();
    wb.validW = 0; wb.regwriteW = 0; wb.memtoregW = 0; wb.aluoutW = 0; wb.readdataW = 0;
    wb.writeregW = 0; wb.instrW = 0; wb.ra1D = 0; wb.ra2D = 0;

    // reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 8);
    drive(0, 1, 1, 0, 32'h55, 0, 5, 32'h1, 5, 0);

    // write r5, confirm, then reset mid-run (coincident commit dropped)
    drive(1, 1, 1, 0, 32'h1234, 32'h0, 5, 32'h100, 1, 2);
    bubble(5, 5);
    drive(0, 1, 1, 0, 32'h9999, 32'h0, 5, 32'h101, 5, 5);
    bubble(5, 0);

    // ALU writeback, visible via bypass then from storage
    drive(1, 1, 1, 0, 32'hDEADBEEF, 32'h0, 8, 32'h200, 8, 0);
    bubble(8, 8);

    // load with both ports bypassing the same register
    drive(1, 1, 1, 1, $urandom, 32'hCAFE0001, 3, 32'h300, 3, 3);
    bubble(3, 8);

    // write to r0 retires but never writes
    drive(1, 1, 1, 0, 32'hFFFFFFFF, 32'h0, 0, 32'h400, 0, 0);
    bubble(0, 3);

    // bubbles aimed at r7 are ignored
    drive(1, 1, 1, 0, 32'h77, 32'h0, 7, 32'h500, 7, 0);
    for (int i = 0; i < 10; i++)
      drive(1, 0, 1, $urandom_range(0, 1), $urandom, $urandom, 7, $urandom, 7, 7);
    bubble(7, 0);

    // counter wrap: 17 retires with CNT_W=4
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++)
      drive(1, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
            AW'($urandom), 32'hA000_0000 + i, AW'($urandom), AW'($urandom));
    bubble(1, 2);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom, $urandom, AW'($urandom), $urandom,
            AW'($urandom), AW'($urandom));
    end
    bubble(0, 0);

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #3;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
